sump_cmd_decoder: RTL and testbench

//   Command decoder for the SUMP host link. It assembles bytes from the UART receiver into

---
 rtl/sump_cmd_decoder.sv | 182 ++++++++++++++++++
 tb/tb_sump_cmd_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sump_cmd_decoder.sv
// SUMP host-link command decoder: assembles UART bytes into short/long commands
// and issues one-cycle strobes with a 32-bit little-endian argument.
module sump_cmd_decoder #(
    parameter int TIMEOUT = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_stb_i,
    output logic [31:0] cmd_o,
    output logic [7:0]  opcode_o,
    output logic        rst_cmd_o,
    output logic        run_o,
    output logic        id_o,
    output logic        xon_o,
    output logic        xoff_o,
    output logic        set_div_o,
    output logic        set_cnt_o,
    output logic        set_flags_o,
    output logic        trg_mask_o,
    output logic        trg_val_o,
    output logic        trg_cfg_o,
    output logic [1:0]  stage_o,
    output logic        err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE,
        S_ARG
    } state_t;

    // Strobe vector bit order: rst, run, id, xon, xoff, div, cnt, flags, mask, val, cfg
    function automatic logic [10:0] decode_op(input logic [7:0] op);
        logic [10:0] v;
        v = '0;
        case (op)
            8'h00:   v[0] = 1'b1;
            8'h01:   v[1] = 1'b1;
            8'h02:   v[2] = 1'b1;
            8'h11:   v[3] = 1'b1;
            8'h13:   v[4] = 1'b1;
            8'h80:   v[5] = 1'b1;
            8'h81:   v[6] = 1'b1;
            8'h82:   v[7] = 1'b1;
            default: begin
                if (op[7:4] == 4'hC) begin
                    case (op[1:0])
                        2'd0:    v[8]  = 1'b1;
                        2'd1:    v[9]  = 1'b1;
                        2'd2:    v[10] = 1'b1;
                        default: v     = '0;
                    endcase
                end
            end
        endcase
        return v;
    endfunction

    state_t          r_state;
    logic [1:0]      r_arg_cnt;
    logic [TW-1:0]   r_tmo;
    logic [7:0]      r_opcode;
    logic [23:0]     r_shift;
    logic [31:0]     r_cmd;
    logic [7:0]      r_opcode_out;
    logic [1:0]      r_stage;
    logic [10:0]     r_strb;
    logic            r_err;

    logic [10:0]     w_rx_dec;
    logic [10:0]     w_op_dec;
    logic [2:0]      w_lane_we;
    logic            w_arg_byte;

    assign w_rx_dec   = decode_op(rx_data_i);
    assign w_op_dec   = decode_op(r_opcode);
    assign w_arg_byte = (r_state == S_ARG) && rx_stb_i;

    // The fourth argument byte is never stored: it is merged straight into cmd_o.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            assign w_lane_we[gi] = w_arg_byte && (r_arg_cnt == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shift <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_lane_we[i]) begin
                    r_shift[8*i +: 8] <= rx_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_arg_cnt    <= '0;
            r_tmo        <= '0;
            r_opcode     <= '0;
            r_cmd        <= '0;
            r_opcode_out <= '0;
            r_stage      <= '0;
            r_strb       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_strb <= '0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_stb_i) begin
                        if (!rx_data_i[7]) begin
                            if (|w_rx_dec) begin
                                r_strb       <= w_rx_dec;
                                r_opcode_out <= rx_data_i;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_opcode  <= rx_data_i;
                            r_arg_cnt <= '0;
                            r_tmo     <= '0;
                            r_state   <= S_ARG;
                        end
                    end
                end
                S_ARG: begin
                    // An arriving byte always takes priority over the timeout.
                    if (rx_stb_i) begin
                        r_tmo <= '0;
                        if (r_arg_cnt == 2'd3) begin
                            r_state   <= S_IDLE;
                            r_arg_cnt <= '0;
                            if (|w_op_dec) begin
                                r_strb       <= w_op_dec;
                                r_cmd        <= {rx_data_i, r_shift};
                                r_opcode_out <= r_opcode;
                                if (|w_op_dec[10:8]) begin
                                    r_stage <= r_opcode[3:2];
                                end
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_arg_cnt <= r_arg_cnt + 2'd1;
                        end
                    end else if (r_tmo == TW'(TIMEOUT)) begin
                        r_err     <= 1'b1;
                        r_state   <= S_IDLE;
                        r_arg_cnt <= '0;
                        r_tmo     <= '0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_o       = r_cmd;
    assign opcode_o    = r_opcode_out;
    assign stage_o     = r_stage;
    assign err_o       = r_err;
    assign rst_cmd_o   = r_strb[0];
    assign run_o       = r_strb[1];
    assign id_o        = r_strb[2];
    assign xon_o       = r_strb[3];
    assign xoff_o      = r_strb[4];
    assign set_div_o   = r_strb[5];
    assign set_cnt_o   = r_strb[6];
    assign set_flags_o = r_strb[7];
    assign trg_mask_o  = r_strb[8];
    assign trg_val_o   = r_strb[9];
    assign trg_cfg_o   = r_strb[10];

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: directed scenarios plus random byte streams, every
// cycle compared against a queue-based command model.
module tb_sump_cmd_decoder;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  rx_data_i = '0;
    logic        rx_stb_i = 1'b0;
    logic [31:0] cmd_o;
    logic [7:0]  opcode_o;
    logic        rst_cmd_o, run_o, id_o, xon_o, xoff_o, set_div_o, set_cnt_o;
    logic        set_flags_o, trg_mask_o, trg_val_o, trg_cfg_o, err_o;
    logic [1:0]  stage_o;

    sump_cmd_decoder #(.TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_stb_i(rx_stb_i),
        .cmd_o(cmd_o), .opcode_o(opcode_o), .rst_cmd_o(rst_cmd_o), .run_o(run_o),
        .id_o(id_o), .xon_o(xon_o), .xoff_o(xoff_o), .set_div_o(set_div_o),
        .set_cnt_o(set_cnt_o), .set_flags_o(set_flags_o), .trg_mask_o(trg_mask_o),
        .trg_val_o(trg_val_o), .trg_cfg_o(trg_cfg_o), .stage_o(stage_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  pend[$];
    int          gap = 0;
    logic [10:0] e_strb = '0;
    logic        e_err = 1'b0;
    logic [31:0] e_cmd = '0;
    logic [7:0]  e_op = '0;
    logic [1:0]  e_stage = '0;

    logic [11:0] obs_strb;
    assign obs_strb = {err_o, trg_cfg_o, trg_val_o, trg_mask_o, set_flags_o, set_cnt_o,
                       set_div_o, xoff_o, xon_o, id_o, run_o, rst_cmd_o};

    // One-hot command table: rst, run, id, xon, xoff, div, cnt, flags, mask, val, cfg
    function automatic logic [10:0] ref_strobe(input logic [7:0] op);
        logic [10:0] v;
        v = '0;
        if (op == 8'h00)      v[0] = 1'b1;
        else if (op == 8'h01) v[1] = 1'b1;
        else if (op == 8'h02) v[2] = 1'b1;
        else if (op == 8'h11) v[3] = 1'b1;
        else if (op == 8'h13) v[4] = 1'b1;
        else if (op == 8'h80) v[5] = 1'b1;
        else if (op == 8'h81) v[6] = 1'b1;
        else if (op == 8'h82) v[7] = 1'b1;
        else if (op >= 8'hC0 && op <= 8'hCF && (op % 4) != 3) v[8 + int'(op % 4)] = 1'b1;
        return v;
    endfunction

    task automatic model(input logic r, input logic s, input logic [7:0] d);
        logic [10:0] v;
        logic [7:0]  op;
        e_strb = '0;
        e_err  = 1'b0;
        if (r) begin
            pend.delete();
            gap = 0; e_cmd = '0; e_op = '0; e_stage = '0;
        end else if (pend.size() == 0) begin
            if (s) begin
                if (d < 8'h80) begin
                    v = ref_strobe(d);
                    if (v != 0) begin e_strb = v; e_op = d; end
                    else e_err = 1'b1;
                end else begin
                    pend.push_back(d);
                    gap = 0;
                end
            end
        end else if (s) begin
            pend.push_back(d);
            gap = 0;
            if (pend.size() == 5) begin
                op = pend[0];
                v  = ref_strobe(op);
                if (v != 0) begin
                    e_strb = v;
                    e_op   = op;
                    e_cmd  = {pend[4], pend[3], pend[2], pend[1]};
                    if (op >= 8'hC0) e_stage = op[3:2];
                end else begin
                    e_err = 1'b1;
                end
                pend.delete();
            end
        end else begin
            gap++;
            if (gap > TMO) begin
                e_err = 1'b1;
                pend.delete();
                gap = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, update the model and compare all outputs.
    task automatic cyc(input logic r, input logic s, input logic [7:0] d);
        rst_i = r; rx_stb_i = s; rx_data_i = d;
        @(posedge clk);
        model(r, s, d);
        #1;
        $display("t=%0t rst=%0b stb=%0b data=%h -> strb=%h cmd=%h op=%h stage=%0d",
                 $time, r, s, d, obs_strb, cmd_o, opcode_o, stage_o);
        chk("strobes", 32'(obs_strb), 32'({e_err, e_strb}));
        chk("cmd", cmd_o, e_cmd);
        chk("opcode", 32'(opcode_o), 32'(e_op));
        chk("stage", 32'(stage_o), 32'(e_stage));
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] pool[14] = '{8'h00, 8'h01, 8'h02, 8'h11, 8'h13, 8'h7F, 8'h80,
                             8'h81, 8'h82, 8'hC4, 8'hC9, 8'hCE, 8'hC3, 8'h90};
    int err_cnt;

    initial begin
        // Reset state
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk("reset_cmd", cmd_o, 32'h0);
        chk("reset_strobes", 32'(obs_strb), 32'h0);

        // 1: reset mid-long-command, then run
        send(8'h80); send(8'h11); send(8'h22);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        send(8'h01);
        chk("t1_run", 32'(run_o), 32'h1);
        idle(1);

        // 2: set count back-to-back
        send(8'h81); send(8'h03); send(8'h00); send(8'h07); send(8'h00);
        chk("t2_set_cnt", 32'(set_cnt_o), 32'h1);
        chk("t2_cmd", cmd_o, 32'h0007_0003);
        chk("t2_opcode", 32'(opcode_o), 32'h81);
        idle(1);
        chk("t2_set_cnt_drop", 32'(set_cnt_o), 32'h0);

        // 3: trigger config stage 1
        send(8'hC6); send(8'hFF); send(8'h00); send(8'hAA); send(8'h55);
        chk("t3_trg_cfg", 32'(trg_cfg_o), 32'h1);
        chk("t3_stage", 32'(stage_o), 32'h1);
        chk("t3_cmd", cmd_o, 32'h55AA_00FF);
        idle(2);

        // 4: five soft resets spaced 3 cycles
        for (int i = 0; i < 5; i++) begin
            send(8'h00);
            chk("t4_rst_cmd", 32'(rst_cmd_o), 32'h1);
            idle(2);
        end

        // 5: argument timeout, then ID request
        send(8'h80); send(8'h12);
        err_cnt = 0;
        for (int i = 0; i < TMO + 3; i++) begin
            cyc(1'b0, 1'b0, 8'h00);
            if (err_o) err_cnt++;
        end
        chk("t5_err_pulses", 32'(err_cnt), 32'd1);
        chk("t5_cmd_kept", cmd_o, 32'h55AA_00FF);
        send(8'h02);
        chk("t5_id", 32'(id_o), 32'h1);

        // 6: unknown short and long opcodes
        send(8'h7F);
        chk("t6_short_err", 32'(err_o), 32'h1);
        send(8'h90); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("t6_long_err", 32'(err_o), 32'h1);
        chk("t6_opcode_kept", 32'(opcode_o), 32'h02);

        // Byte arriving exactly when the idle limit is reached is still accepted
        send(8'h82); send(8'h01); idle(TMO); send(8'h02); send(8'h03); send(8'h04);
        chk("tmo_edge_flags", 32'(set_flags_o), 32'h1);

        // Random streams
        for (int it = 0; it < 2500; it++) begin
            logic r, s;
            logic [7:0] d;
            if ($urandom_range(0, 60) == 0) begin
                idle($urandom_range(TMO - 2, TMO + 3));
            end else begin
                r = ($urandom_range(0, 299) == 0);
                s = ($urandom_range(0, 2) != 0);
                d = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 13)] : 8'($urandom);
                cyc(r, s, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
